pll_lock_reset_seq: RTL and testbench
=====================================

Name: pll_lock_reset_seq

Overview:
- Sits directly downstream of the core PLL wrapper, in the domain of the 50.35 MHz system clock the PLL produces.
- Brings the PLL's asynchronous lock flag into that domain and requires lock to hold for a fixed time.
- Then releases the core, video and audio resets in a fixed order, with a gap between each.
- Any loss of lock, or an external reset request, re-asserts all resets at once and restarts the sequence.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on pll_locked_async (minimum 2).
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before rst_core_out is released (minimum 1).
- GAP_CYCLES, 16, cycles between successive reset releases (minimum 1).
- CNT_W, 16, width of the shared down-counter; must hold max(STABLE_CYCLES, GAP_CYCLES)-1.
- LOSS_W, 8, width of the lock-loss counter (optional feature only).

Ports:
- clk  in  1  system clock (PLL output).
- rst  in  1  synchronous, active-high reset.
- pll_locked_async  in  1  PLL locked flag, asynchronous to clk.
- reset_req  in  1  synchronous request to re-run the reset sequence; level-sensitive.
- rst_core_out  out  1  active-high reset for core logic; released first.
- rst_video_out  out  1  active-high reset for video pipeline; released second.
- rst_audio_out  out  1  active-high reset for audio; released last.
- ready  out  1  high while all resets are released.
- lock_lost_pulse  out  1  one-cycle pulse when lock drops after any reset has been released.
- loss_count  out  LOSS_W  saturating count of lock-loss events (optional feature only).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values while rst=1:
  - synchronizer flops 0; state WAIT_LOCK; counter 0;
  - rst_core_out = rst_video_out = rst_audio_out = 1;
  - ready = 0; lock_lost_pulse = 0; loss_count = 0.
- Outputs: all registered; no combinational path from any input to any output.
- Synchronizer: pll_locked_async passes through SYNC_STAGES flops to give locked_s. Define go = locked_s & ~reset_req.
- WAIT_LOCK: all resets 1, ready 0. If go, load counter with STABLE_CYCLES-1 and go to STABLE.
- STABLE:
  - If !go, go to WAIT_LOCK. No pulse.
  - Else if counter==0, go to REL_CORE, load counter with GAP_CYCLES-1, and clear rst_core_out on that edge.
  - Else decrement the counter.
- REL_CORE: rst_core_out=0. When counter==0, go to REL_VIDEO, load GAP_CYCLES-1, clear rst_video_out. Else decrement.
- REL_VIDEO: when counter==0, go to RUN, clear rst_audio_out, set ready. Else decrement.
- RUN: hold state; counter idle.
- Abort (applies in REL_CORE, REL_VIDEO and RUN):
  - If !go, then on the next edge all resets go to 1, ready goes to 0, and state returns to WAIT_LOCK.
  - If locked_s=0 at that time, lock_lost_pulse=1 for exactly that one cycle, whether or not reset_req is also high.
  - reset_req alone never pulses.
- Release latency: the first edge that samples pll_locked_async=1 is edge 1.
  - locked_s=1 after edge SYNC_STAGES; the FSM enters STABLE at edge SYNC_STAGES+1.
  - rst_core_out falls at edge SYNC_STAGES+STABLE_CYCLES+1.
  - rst_video_out falls GAP_CYCLES edges later; rst_audio_out and ready fall/rise a further GAP_CYCLES edges later.
- Glitch rule: a lock glitch shorter than the stable window during STABLE restarts the full window. No partial credit.
- Ordering invariant: rst_video_out=0 implies rst_core_out=0; rst_audio_out=0 implies rst_video_out=0. ready equals ~rst_audio_out.
- rst mid-sequence: everything returns to reset values on the next edge, including the synchronizer flops.

Optional Feature:
- Macro: PLL_LOCK_LOSS_COUNT_EN.
- Defined: the loss_count port exists. It increments by 1 on every cycle where lock_lost_pulse=1 and saturates at 2^LOSS_W-1. It is cleared only by rst.
- Undefined: the loss_count port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package pll_rst_pkg:
  - state enum: WAIT_LOCK, STABLE, REL_CORE, REL_VIDEO, RUN;
  - default constants for STABLE_CYCLES and GAP_CYCLES.
- One sub-module, sync_bit: a parameterized SYNC_STAGES-deep single-bit synchronizer with synchronous reset to 0. Other blocks that cross PLL domains reuse it.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=8, GAP_CYCLES=4, LOSS_W=2):
- Clean lock: rst released, pll_locked_async rises before edge 1 and stays high -> rst_core_out falls at edge 11, rst_video_out at edge 15, rst_audio_out falls and ready rises at edge 19; lock_lost_pulse never asserts.
- Glitch in STABLE: lock drops for 1 cycle 5 cycles after locked_s rises -> no pulse; rst_core_out falls 8 cycles after locked_s returns high.
- Loss in RUN: drop pll_locked_async -> 3 edges after the drop edge, all resets are 1, ready 0, lock_lost_pulse high for 1 cycle; relock repeats the 8/4/4 sequence.
- reset_req in REL_VIDEO: held 3 cycles -> all resets 1 on the next edge, no pulse; the sequence restarts 8 cycles after reset_req falls.
- Simultaneous events: reset_req high on the same cycle locked_s falls in RUN -> pulse=1 for one cycle; loss_count increments once.
- Saturation (PLL_LOCK_LOSS_COUNT_EN): 5 lock-loss events -> loss_count reads 1, 2, 3, 3, 3. rst mid-REL_CORE -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL lock / reset release sequencer.
package pll_rst_pkg;

  // Sequencer states, in release order.
  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    REL_CORE,
    REL_VIDEO,
    RUN
  } state_t;

  // Default lock-stable window and gap between successive reset releases.
  localparam int STABLE_CYCLES_DEF = 1024;
  localparam int GAP_CYCLES_DEF    = 16;

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous reset to 0.
// Reused wherever a level crosses into a PLL-generated clock domain.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_p;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) sync_p <= '0;
    else     sync_p <= {sync_p[SYNC_STAGES-2:0], d};
  end

  assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL lock qualification and ordered reset release (core, video, audio).
// Optional saturating lock-loss counter enabled by PLL_LOCK_LOSS_COUNT_EN.
module pll_lock_reset_seq
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int GAP_CYCLES    = GAP_CYCLES_DEF,
  parameter int CNT_W         = 16
`ifdef PLL_LOCK_LOSS_COUNT_EN
  ,
  parameter int LOSS_W        = 8
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked_async,
  input  logic reset_req,
  output logic rst_core_out,
  output logic rst_video_out,
  output logic rst_audio_out,
  output logic ready,
  output logic lock_lost_pulse
`ifdef PLL_LOCK_LOSS_COUNT_EN
  ,
  output logic [LOSS_W-1:0] loss_count
`endif
);

  localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

  logic             locked_s;
  logic             go;
  logic             abort;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             core_n, video_n, audio_n, pulse_n;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked_async),
    .q   (locked_s)
  );

  assign go = locked_s & ~reset_req;

  // Once any reset has been released, losing go drops everything at once.
  assign abort = ~go & ((state == REL_CORE) | (state == REL_VIDEO) | (state == RUN));

  // State, counter and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= WAIT_LOCK;
      cnt             <= '0;
      rst_core_out    <= 1'b1;
      rst_video_out   <= 1'b1;
      rst_audio_out   <= 1'b1;
      ready           <= 1'b0;
      lock_lost_pulse <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      rst_core_out    <= core_n;
      rst_video_out   <= video_n;
      rst_audio_out   <= audio_n;
      ready           <= ~audio_n;
      lock_lost_pulse <= pulse_n;
    end
  end

  // Next state, counter and reset levels; any drop of lock in STABLE
  // restarts the full window because WAIT_LOCK reloads the counter.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    core_n  = rst_core_out;
    video_n = rst_video_out;
    audio_n = rst_audio_out;
    pulse_n = 1'b0;
    if (abort) begin
      state_n = WAIT_LOCK;
      cnt_n   = '0;
      core_n  = 1'b1;
      video_n = 1'b1;
      audio_n = 1'b1;
      pulse_n = ~locked_s;
    end else begin
      case (state)
        WAIT_LOCK: begin
          core_n  = 1'b1;
          video_n = 1'b1;
          audio_n = 1'b1;
          if (go) begin
            state_n = STABLE;
            cnt_n   = STABLE_LOAD;
          end
        end
        STABLE: begin
          if (!go) begin
            state_n = WAIT_LOCK;
          end else if (cnt == '0) begin
            state_n = REL_CORE;
            cnt_n   = GAP_LOAD;
            core_n  = 1'b0;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        REL_CORE: begin
          if (cnt == '0) begin
            state_n = REL_VIDEO;
            cnt_n   = GAP_LOAD;
            video_n = 1'b0;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        REL_VIDEO: begin
          if (cnt == '0) begin
            state_n = RUN;
            audio_n = 1'b0;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        RUN: begin
          state_n = RUN;
        end
        default: begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
          core_n  = 1'b1;
          video_n = 1'b1;
          audio_n = 1'b1;
        end
      endcase
    end
  end

`ifdef PLL_LOCK_LOSS_COUNT_EN
  // Saturating count of lock-loss pulses; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst)                                       loss_count <= '0;
    else if (lock_lost_pulse && (loss_count != '1)) loss_count <= loss_count + LOSS_W'(1);
  end
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq with an event scoreboard on the outputs.
// Output vector layout: {rst_core_out, rst_video_out, rst_audio_out, ready, lock_lost_pulse}.
module tb_pll_lock_reset_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked_async = 1'b0;
  logic reset_req = 1'b0;
  logic rst_core_out, rst_video_out, rst_audio_out, ready, lock_lost_pulse;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [1:0] loss_count;
  int losses = 0;
`endif

  pll_lock_reset_seq #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .GAP_CYCLES    (4),
    .CNT_W         (16)
`ifdef PLL_LOCK_LOSS_COUNT_EN
    ,
    .LOSS_W        (2)
`endif
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pll_locked_async (pll_locked_async),
    .reset_req        (reset_req),
    .rst_core_out     (rst_core_out),
    .rst_video_out    (rst_video_out),
    .rst_audio_out    (rst_audio_out),
    .ready            (ready),
    .lock_lost_pulse  (lock_lost_pulse)
`ifdef PLL_LOCK_LOSS_COUNT_EN
    ,
    .loss_count       (loss_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
    string      tag;
  } exp_t;
  exp_t sb[$];

  logic       mon_en = 1'b0;
  logic [4:0] prev;
  wire  [4:0] obs = {rst_core_out, rst_video_out, rst_audio_out, ready, lock_lost_pulse};

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic expect_at(input int c, input logic [4:0] v, input string tag);
    sb.push_back('{c, v, tag});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  // Every output change must match the next scheduled event, on its cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        check({sb[0].tag, " missed"}, 32'(cyc), 32'(sb[0].cyc));
        void'(sb.pop_front());
      end
      if (obs !== prev) begin
        if (sb.size() == 0) begin
          check("unexpected output change", 32'(obs), 32'(prev));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.tag, " cycle"}, 32'(cyc), 32'(e.cyc));
          check({e.tag, " value"}, 32'(obs), 32'(e.vec));
        end
        prev = obs;
      end
      check("ordering invariant",
            32'((ready === ~rst_audio_out) && (rst_video_out || !rst_core_out) &&
                (rst_audio_out || !rst_video_out)), 32'(1));
    end
  end

`ifdef PLL_LOCK_LOSS_COUNT_EN
  task automatic check_loss(input string tag);
    check(tag, 32'(loss_count), 32'((losses > 3) ? 3 : losses));
  endtask
`endif

  initial begin
    int t;
    int u;
    int v;
    int w;

    // Reset state
    step(3);
    check("reset outputs", 32'(obs), 32'(5'b11100));
`ifdef PLL_LOCK_LOSS_COUNT_EN
    check_loss("reset loss_count");
`endif
    prev   = obs;
    mon_en = 1'b1;

    // Clean lock: edge 1 is t+1; releases at edges 11, 15, 19
    rst = 1'b0;
    pll_locked_async = 1'b1;
    t = cyc;
    expect_at(t + 11, 5'b01100, "clean core release");
    expect_at(t + 15, 5'b00100, "clean video release");
    expect_at(t + 19, 5'b00010, "clean audio release");
    wait_until(t + 22);

    // Loss in RUN: sampled t+1, locked_s low t+2, abort t+3, pulse ends t+4
    pll_locked_async = 1'b0;
    t = cyc;
    expect_at(t + 3, 5'b11101, "run loss abort");
    expect_at(t + 4, 5'b11100, "run loss pulse end");
    wait_until(t + 4);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    losses++;
    check_loss("loss_count after event 1");
`endif
    wait_until(t + 6);

    // Relock with a one-cycle glitch 5 cycles after locked_s rises (t+2);
    // locked_s back high at t+10, STABLE re-entered t+11, core falls t+19
    pll_locked_async = 1'b1;
    t = cyc;
    wait_until(t + 7);
    pll_locked_async = 1'b0;
    wait_until(t + 8);
    pll_locked_async = 1'b1;
    expect_at(t + 19, 5'b01100, "glitch core release");
    expect_at(t + 23, 5'b00100, "glitch video release");
    expect_at(t + 27, 5'b00010, "glitch audio release");
    wait_until(t + 30);

    // reset_req in RUN for one cycle: abort without a pulse, restart
    reset_req = 1'b1;
    u = cyc;
    expect_at(u + 1, 5'b11100, "req abort in run");
    wait_until(u + 1);
    reset_req = 1'b0;
    expect_at(u + 10, 5'b01100, "req restart core");
    expect_at(u + 14, 5'b00100, "req restart video");
    // reset_req in REL_VIDEO held 3 cycles; STABLE at u+19, core falls u+27
    wait_until(u + 15);
    reset_req = 1'b1;
    expect_at(u + 16, 5'b11100, "req abort in video");
    wait_until(u + 18);
    reset_req = 1'b0;
    expect_at(u + 27, 5'b01100, "req rerun core");
    expect_at(u + 31, 5'b00100, "req rerun video");
    expect_at(u + 35, 5'b00010, "req rerun audio");
    wait_until(u + 38);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    check_loss("loss_count unchanged by reset_req");
`endif

    // Simultaneous: reset_req rises on the cycle locked_s is already low
    pll_locked_async = 1'b0;
    v = cyc;
    wait_until(v + 2);
    reset_req = 1'b1;
    expect_at(v + 3, 5'b11101, "simultaneous abort");
    expect_at(v + 4, 5'b11100, "simultaneous pulse end");
    wait_until(v + 4);
    reset_req = 1'b0;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    losses++;
    check_loss("loss_count after event 2");
`endif
    wait_until(v + 6);

    // Three further losses, each in REL_CORE
    for (int k = 0; k < 3; k++) begin
      pll_locked_async = 1'b1;
      w = cyc;
      expect_at(w + 11, 5'b01100, "loop core release");
      wait_until(w + 12);
      pll_locked_async = 1'b0;
      expect_at(w + 15, 5'b11101, "core loss abort");
      expect_at(w + 16, 5'b11100, "core loss pulse end");
      wait_until(w + 16);
`ifdef PLL_LOCK_LOSS_COUNT_EN
      losses++;
      check_loss("loss_count saturating");
`endif
      wait_until(w + 18);
    end

    // rst mid-REL_CORE: reset values next edge, then a full restart
    pll_locked_async = 1'b1;
    w = cyc;
    expect_at(w + 11, 5'b01100, "pre-rst core release");
    wait_until(w + 12);
    rst = 1'b1;
    expect_at(w + 13, 5'b11100, "rst mid rel_core");
    wait_until(w + 13);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    losses = 0;
    check_loss("loss_count cleared by rst");
`endif
    rst = 1'b0;
    t = cyc;
    expect_at(t + 11, 5'b01100, "post-rst core release");
    expect_at(t + 15, 5'b00100, "post-rst video release");
    expect_at(t + 19, 5'b00010, "post-rst audio release");
    wait_until(t + 22);

    mon_en = 1'b0;
    check("scoreboard drained", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
